auth_request_queue: RTL and testbench
=====================================

AUTH_REQUEST_QUEUE -- requirements
Module: auth_request_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16): entries per request queue.
REQ-002 SHALL have ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
REQ-003 SHALL have PD request port inputs:
- PD_req_in  input  8  request code {slot[7:6], init_resp[5:4], usb[3:2], type[1:0]}
- PD_req_valid  input  1  push strobe
REQ-004 SHALL have DEBUG request port inputs: DEBUG_req_in (8) and DEBUG_req_valid (1), same meaning as REQ-003.
REQ-005 SHALL have ready outputs:
- PD_req_ready  output  1  PD queue not full
- DEBUG_req_ready  output  1  DEBUG queue not full
REQ-006 SHALL have pending-request outputs:
- pending_auth_request_PD  output  8  PD queue head; 0 when empty
- pending_auth_request_DEBUG  output  8  DEBUG queue head; 0 when empty
REQ-007 SHALL have erase inputs: pending_auth_request_PD_erase (1) and pending_auth_request_DEBUG_erase (1), each a level from the authentication driver; a pop is triggered on the rising edge.
REQ-008 SHALL have status outputs:
- PD_count  output  $clog2(DEPTH)+1  PD occupancy
- DEBUG_count  output  $clog2(DEPTH)+1  DEBUG occupancy
- PD_overflow  output  1  sticky
- DEBUG_overflow  output  1  sticky
- Error_invalid_request  output  1  one-cycle pulse

Function
REQ-009 SHALL implement two independent circular FIFOs (PD, DEBUG), each DEPTH x 8, with wrapping read/write pointers.
REQ-010 SHALL push on a rising clk edge when req_valid=1 and ready=1; ready is derived from the registered count (count<DEPTH).
REQ-011 SHALL make a pushed entry visible on the pending output one cycle after the push when the queue was empty.
REQ-012 SHALL register all pending outputs; each pending output equals the head entry, or 8'h00 when count=0.
REQ-013 SHALL pop exactly one entry per erase rising edge (erase=1 with erase_prev=0); a held-high erase SHALL NOT pop again.
REQ-014 SHALL ignore a pop on an empty queue: no count change, no flag.
REQ-015 SHALL handle a simultaneous push and pop on a non-full, non-empty queue by performing both; count is unchanged and the next entry is presented next cycle.
REQ-016 SHALL refuse a push when full, even if a pop occurs in the same cycle; PD_overflow/DEBUG_overflow then SHALL set and hold until reset.
REQ-017 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on both or neither; count never exceeds DEPTH and never underflows.
REQ-018 SHALL keep the PD and DEBUG queues fully independent; simultaneous activity on both SHALL NOT interact.

Reset
REQ-019 SHALL, while reset=0 at a clk edge, clear both pointers and counts and drive pending outputs to 0, ready outputs to 1, overflow flags to 0 and Error_invalid_request to 0.
REQ-020 SHALL set both erase_prev registers to 1 in reset, so an erase held high through reset release does not pop.
REQ-021 SHALL apply reset mid-operation by discarding queued entries; stored data bits need not be cleared.

Configuration
REQ-022 SHALL, when AUTH_REQ_DROP_INVALID_EN is defined, refuse any push whose bits[5:4] are 2'b00 or 2'b11 (no storage, no count change) and pulse Error_invalid_request for one cycle; the overflow check takes priority over this check.
REQ-023 SHALL, when AUTH_REQ_DROP_INVALID_EN is undefined, store every code, tie Error_invalid_request to 0, and include no filter logic.

Verification
REQ-024 Reset with PD_erase held at 1; push PD 8'h54 -> pending_auth_request_PD=8'h54 next cycle, PD_count=1, no pop at reset release.
REQ-025 Push DEBUG 8'h21, 8'h62, 8'h9A, 8'h15; push a fifth -> DEBUG_req_ready=0, DEBUG_overflow=1, DEBUG_count=4, head still 8'h21.
REQ-026 Hold DEBUG_erase at 1 for 5 cycles after REQ-025 -> exactly one pop, head=8'h62, count=3; drop erase then raise again -> head=8'h9A.
REQ-027 Queue of count 2; same-cycle push 8'h24 and erase edge -> count stays 2; entries drain in FIFO order; pointers wrap correctly over 3*DEPTH operations.
REQ-028 With AUTH_REQ_DROP_INVALID_EN defined, push PD 8'h0C -> not stored, Error_invalid_request pulses 1 cycle; without the macro -> stored, PD_count=1.
REQ-029 Drive random simultaneous PD/DEBUG pushes and erases, then assert reset mid-stream -> both counts=0, pending outputs=0, overflow flags cleared; against a scoreboard, no cross-queue corruption.

Source files
------------

// File: rtl/auth_request_queue.sv
// auth_request_queue: two independent DEPTH x 8 circular request FIFOs, one for the PD port and
// one for the DEBUG port. Heads are presented on registered pending outputs. An erase rising edge
// pops one entry, and a push into a full queue sets a sticky overflow flag.
// Optional feature: define AUTH_REQ_DROP_INVALID_EN to refuse codes whose init_resp field
// (bits [5:4]) is 2'b00 or 2'b11. A refused code pulses Error_invalid_request.
module auth_request_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              PD_req_in,
  input  logic                    PD_req_valid,
  input  logic [7:0]              DEBUG_req_in,
  input  logic                    DEBUG_req_valid,
  output logic                    PD_req_ready,
  output logic                    DEBUG_req_ready,
  output logic [7:0]              pending_auth_request_PD,
  output logic [7:0]              pending_auth_request_DEBUG,
  input  logic                    pending_auth_request_PD_erase,
  input  logic                    pending_auth_request_DEBUG_erase,
  output logic [$clog2(DEPTH):0]  PD_count,
  output logic [$clog2(DEPTH):0]  DEBUG_count,
  output logic                    PD_overflow,
  output logic                    DEBUG_overflow,
  output logic                    Error_invalid_request
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned NumQ = 2;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Index 0 is the PD queue, index 1 is the DEBUG queue.
  logic [7:0]      req_in       [NumQ];
  logic            req_valid    [NumQ];
  logic            erase        [NumQ];
  logic            ready        [NumQ];
  logic            code_ok      [NumQ];
  logic            push         [NumQ];
  logic            pop          [NumQ];
  logic [7:0]      head         [NumQ];

  logic [7:0]      mem_q        [NumQ][DEPTH];
  logic [PtrW-1:0] rd_ptr_q     [NumQ];
  logic [PtrW-1:0] rd_ptr_d     [NumQ];
  logic [PtrW-1:0] wr_ptr_q     [NumQ];
  logic [PtrW-1:0] wr_ptr_d     [NumQ];
  logic [CntW-1:0] count_q      [NumQ];
  logic [CntW-1:0] count_d      [NumQ];
  logic [7:0]      pending_q    [NumQ];
  logic [7:0]      pending_d    [NumQ];
  logic            ovf_q        [NumQ];
  logic            ovf_d        [NumQ];
  logic            erase_prev_q [NumQ];

  assign req_in[0]    = PD_req_in;
  assign req_in[1]    = DEBUG_req_in;
  assign req_valid[0] = PD_req_valid;
  assign req_valid[1] = DEBUG_req_valid;
  assign erase[0]     = pending_auth_request_PD_erase;
  assign erase[1]     = pending_auth_request_DEBUG_erase;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full queue.
  always_comb begin
    for (int q = 0; q < NumQ; q++) begin
      ready[q] = (count_q[q] < CntFull);
    end
  end

`ifdef AUTH_REQ_DROP_INVALID_EN
  logic err_q;
  logic err_d;

  // Accept only init_resp 01/10; a full queue reports overflow instead of an invalid code.
  always_comb begin
    err_d = 1'b0;
    for (int q = 0; q < NumQ; q++) begin
      code_ok[q] = (req_in[q][5:4] == 2'b01) || (req_in[q][5:4] == 2'b10);
      err_d      = err_d | (req_valid[q] & ready[q] & ~code_ok[q]);
    end
  end

  // One-cycle error pulse register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign Error_invalid_request = err_q;
`else
  // Every code is stored.
  always_comb begin
    for (int q = 0; q < NumQ; q++) begin
      code_ok[q] = 1'b1;
    end
  end

  assign Error_invalid_request = 1'b0;
`endif

  // Next-state for pointers, counts, overflow and the registered head of each queue.
  always_comb begin
    for (int q = 0; q < NumQ; q++) begin
      push[q]     = req_valid[q] & ready[q] & code_ok[q];
      pop[q]      = erase[q] & ~erase_prev_q[q] & (count_q[q] != '0);
      wr_ptr_d[q] = push[q] ? wr_ptr_q[q] + 1'b1 : wr_ptr_q[q];
      rd_ptr_d[q] = pop[q] ? rd_ptr_q[q] + 1'b1 : rd_ptr_q[q];
      case ({push[q], pop[q]})
        2'b10:   count_d[q] = count_q[q] + 1'b1;
        2'b01:   count_d[q] = count_q[q] - 1'b1;
        default: count_d[q] = count_q[q];
      endcase
      // The new head may be the entry being written this cycle, which is not in mem_q yet.
      head[q]      = (push[q] && (rd_ptr_d[q] == wr_ptr_q[q])) ? req_in[q]
                                                              : mem_q[q][rd_ptr_d[q]];
      pending_d[q] = (count_d[q] == '0) ? 8'h00 : head[q];
      ovf_d[q]     = ovf_q[q] | (req_valid[q] & ~ready[q]);
    end
  end

  // Control state registers; erase_prev resets high so an erase held through reset cannot pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int q = 0; q < NumQ; q++) begin
        rd_ptr_q[q]     <= '0;
        wr_ptr_q[q]     <= '0;
        count_q[q]      <= '0;
        pending_q[q]    <= 8'h00;
        ovf_q[q]        <= 1'b0;
        erase_prev_q[q] <= 1'b1;
      end
    end else begin
      for (int q = 0; q < NumQ; q++) begin
        rd_ptr_q[q]     <= rd_ptr_d[q];
        wr_ptr_q[q]     <= wr_ptr_d[q];
        count_q[q]      <= count_d[q];
        pending_q[q]    <= pending_d[q];
        ovf_q[q]        <= ovf_d[q];
        erase_prev_q[q] <= erase[q];
      end
    end
  end

  // Storage array; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NumQ; q++) begin
      if (push[q]) begin
        mem_q[q][wr_ptr_q[q]] <= req_in[q];
      end
    end
  end

  assign PD_req_ready               = ready[0];
  assign DEBUG_req_ready            = ready[1];
  assign pending_auth_request_PD    = pending_q[0];
  assign pending_auth_request_DEBUG = pending_q[1];
  assign PD_count                   = count_q[0];
  assign DEBUG_count                = count_q[1];
  assign PD_overflow                = ovf_q[0];
  assign DEBUG_overflow             = ovf_q[1];

endmodule

// File: tb/tb_auth_request_queue.sv
// tb_auth_request_queue: directed vector table plus a queue-model driven wrap and random test.
module tb_auth_request_queue;

  localparam int Depth = 4;

  logic       clk;
  logic       reset;
  logic [7:0] PD_req_in;
  logic       PD_req_valid;
  logic [7:0] DEBUG_req_in;
  logic       DEBUG_req_valid;
  logic       PD_req_ready;
  logic       DEBUG_req_ready;
  logic [7:0] pending_auth_request_PD;
  logic [7:0] pending_auth_request_DEBUG;
  logic       pending_auth_request_PD_erase;
  logic       pending_auth_request_DEBUG_erase;
  logic [2:0] PD_count;
  logic [2:0] DEBUG_count;
  logic       PD_overflow;
  logic       DEBUG_overflow;
  logic       Error_invalid_request;

  auth_request_queue #(.DEPTH(Depth)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .PD_req_in                        (PD_req_in),
    .PD_req_valid                     (PD_req_valid),
    .DEBUG_req_in                     (DEBUG_req_in),
    .DEBUG_req_valid                  (DEBUG_req_valid),
    .PD_req_ready                     (PD_req_ready),
    .DEBUG_req_ready                  (DEBUG_req_ready),
    .pending_auth_request_PD          (pending_auth_request_PD),
    .pending_auth_request_DEBUG       (pending_auth_request_DEBUG),
    .pending_auth_request_PD_erase    (pending_auth_request_PD_erase),
    .pending_auth_request_DEBUG_erase (pending_auth_request_DEBUG_erase),
    .PD_count                         (PD_count),
    .DEBUG_count                      (DEBUG_count),
    .PD_overflow                      (PD_overflow),
    .DEBUG_overflow                   (DEBUG_overflow),
    .Error_invalid_request            (Error_invalid_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       pd_v;
    logic [7:0] pd_d;
    logic       pd_e;
    logic       db_v;
    logic [7:0] db_d;
    logic       db_e;
    logic [7:0] pd_pend;
    logic [7:0] db_pend;
    int         pd_cnt;
    int         db_cnt;
    logic       pd_rdy;
    logic       db_rdy;
    logic       pd_ovf;
    logic       db_ovf;
    logic       err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard state for the model-driven sequences.
  logic [7:0] pdq[$];
  logic [7:0] dbq[$];
  logic       m_prev_pd = 1'b1;
  logic       m_prev_db = 1'b1;
  logic       m_ovf_pd  = 1'b0;
  logic       m_ovf_db  = 1'b0;

  function automatic vec_t mk(input logic rst, input logic pd_v, input logic [7:0] pd_d,
                              input logic pd_e, input logic db_v, input logic [7:0] db_d,
                              input logic db_e, input logic [7:0] pd_pend,
                              input logic [7:0] db_pend, input int pd_cnt, input int db_cnt,
                              input logic pd_rdy, input logic db_rdy, input logic pd_ovf,
                              input logic db_ovf);
    vec_t v;
    v.rst = rst; v.pd_v = pd_v; v.pd_d = pd_d; v.pd_e = pd_e;
    v.db_v = db_v; v.db_d = db_d; v.db_e = db_e;
    v.pd_pend = pd_pend; v.db_pend = db_pend; v.pd_cnt = pd_cnt; v.db_cnt = db_cnt;
    v.pd_rdy = pd_rdy; v.db_rdy = db_rdy; v.pd_ovf = pd_ovf; v.db_ovf = db_ovf;
    v.err = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; sample 1 time unit after the rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset                            = v.rst;
    PD_req_valid                     = v.pd_v;
    PD_req_in                        = v.pd_d;
    pending_auth_request_PD_erase    = v.pd_e;
    DEBUG_req_valid                  = v.db_v;
    DEBUG_req_in                     = v.db_d;
    pending_auth_request_DEBUG_erase = v.db_e;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input vec_t v, input string name);
    chk({name, " pd_pend"}, 32'(pending_auth_request_PD), 32'(v.pd_pend));
    chk({name, " db_pend"}, 32'(pending_auth_request_DEBUG), 32'(v.db_pend));
    chk({name, " pd_cnt"}, 32'(PD_count), v.pd_cnt);
    chk({name, " db_cnt"}, 32'(DEBUG_count), v.db_cnt);
    chk({name, " pd_rdy"}, 32'(PD_req_ready), 32'(v.pd_rdy));
    chk({name, " db_rdy"}, 32'(DEBUG_req_ready), 32'(v.db_rdy));
    chk({name, " pd_ovf"}, 32'(PD_overflow), 32'(v.pd_ovf));
    chk({name, " db_ovf"}, 32'(DEBUG_overflow), 32'(v.db_ovf));
    chk({name, " err"}, 32'(Error_invalid_request), 32'(v.err));
  endtask

  // Advance the queue model by one cycle, then drive the same stimulus and compare.
  task automatic step_model(input string name, input logic rst, input logic pdv,
                            input logic [7:0] pdd, input logic pde, input logic dbv,
                            input logic [7:0] dbd, input logic dbe);
    vec_t v;
    logic rdy;
    if (!rst) begin
      pdq.delete();
      dbq.delete();
      m_prev_pd = 1'b1;
      m_prev_db = 1'b1;
      m_ovf_pd  = 1'b0;
      m_ovf_db  = 1'b0;
    end else begin
      rdy = (pdq.size() < Depth);
      if (pdv && !rdy) m_ovf_pd = 1'b1;
      if (pde && !m_prev_pd && pdq.size() > 0) void'(pdq.pop_front());
      if (pdv && rdy) pdq.push_back(pdd);
      m_prev_pd = pde;
      rdy = (dbq.size() < Depth);
      if (dbv && !rdy) m_ovf_db = 1'b1;
      if (dbe && !m_prev_db && dbq.size() > 0) void'(dbq.pop_front());
      if (dbv && rdy) dbq.push_back(dbd);
      m_prev_db = dbe;
    end
    v = mk(rst, pdv, pdd, pde, dbv, dbd, dbe,
           (pdq.size() > 0) ? pdq[0] : 8'h00, (dbq.size() > 0) ? dbq[0] : 8'h00,
           pdq.size(), dbq.size(), pdq.size() < Depth, dbq.size() < Depth, m_ovf_pd, m_ovf_db);
    apply(v);
    check_vec(v, name);
  endtask

  vec_t tbl[36];

  initial begin
    vec_t v;
    logic [7:0] pd_d;
    logic [7:0] db_d;

    reset = 1'b0; PD_req_valid = 1'b0; PD_req_in = 8'h00; pending_auth_request_PD_erase = 1'b1;
    DEBUG_req_valid = 1'b0; DEBUG_req_in = 8'h00; pending_auth_request_DEBUG_erase = 1'b0;

    //             rst pv pd     pe dv db     de | pd_p   db_p   pc dc pr dr po do
    tbl[0]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(1, 1, 8'h54, 1, 0, 8'h00, 0, 8'h54, 8'h00, 1, 0, 1, 1, 0, 0);
    tbl[3]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h54, 8'h00, 1, 0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h54, 8'h00, 1, 0, 1, 1, 0, 0);
    tbl[5]  = mk(1, 0, 8'h00, 0, 1, 8'h21, 0, 8'h54, 8'h21, 1, 1, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 8'h00, 0, 1, 8'h62, 0, 8'h54, 8'h21, 1, 2, 1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 8'h00, 0, 1, 8'h9A, 0, 8'h54, 8'h21, 1, 3, 1, 1, 0, 0);
    tbl[8]  = mk(1, 0, 8'h00, 0, 1, 8'h15, 0, 8'h54, 8'h21, 1, 4, 1, 0, 0, 0);
    tbl[9]  = mk(1, 0, 8'h00, 0, 1, 8'h77, 0, 8'h54, 8'h21, 1, 4, 1, 0, 0, 1);
    tbl[10] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h62, 1, 3, 1, 1, 0, 1);
    tbl[11] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h62, 1, 3, 1, 1, 0, 1);
    tbl[12] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h62, 1, 3, 1, 1, 0, 1);
    tbl[13] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h62, 1, 3, 1, 1, 0, 1);
    tbl[14] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h62, 1, 3, 1, 1, 0, 1);
    tbl[15] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h54, 8'h62, 1, 3, 1, 1, 0, 1);
    tbl[16] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h9A, 1, 2, 1, 1, 0, 1);
    tbl[17] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h54, 8'h9A, 1, 2, 1, 1, 0, 1);
    tbl[18] = mk(1, 0, 8'h00, 0, 1, 8'h24, 1, 8'h54, 8'h15, 1, 2, 1, 1, 0, 1);
    tbl[19] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h54, 8'h15, 1, 2, 1, 1, 0, 1);
    tbl[20] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h24, 1, 1, 1, 1, 0, 1);
    tbl[21] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h54, 8'h24, 1, 1, 1, 1, 0, 1);
    tbl[22] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h00, 1, 0, 1, 1, 0, 1);
    tbl[23] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h54, 8'h00, 1, 0, 1, 1, 0, 1);
    tbl[24] = mk(1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h00, 1, 0, 1, 1, 0, 1);
    tbl[25] = mk(1, 1, 8'h11, 0, 0, 8'h00, 0, 8'h54, 8'h00, 2, 0, 1, 1, 0, 1);
    tbl[26] = mk(1, 1, 8'h23, 0, 0, 8'h00, 0, 8'h54, 8'h00, 3, 0, 1, 1, 0, 1);
    tbl[27] = mk(1, 1, 8'h56, 0, 0, 8'h00, 0, 8'h54, 8'h00, 4, 0, 0, 1, 0, 1);
    tbl[28] = mk(1, 1, 8'h58, 1, 0, 8'h00, 0, 8'h11, 8'h00, 3, 0, 1, 1, 1, 1);
    tbl[29] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h11, 8'h00, 3, 0, 1, 1, 1, 1);
    tbl[30] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h23, 8'h00, 2, 0, 1, 1, 1, 1);
    tbl[31] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h23, 8'h00, 2, 0, 1, 1, 1, 1);
    tbl[32] = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h56, 8'h00, 1, 0, 1, 1, 1, 1);
    tbl[33] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h56, 8'h00, 1, 0, 1, 1, 1, 1);
    tbl[34] = mk(1, 1, 8'h5A, 1, 0, 8'h00, 0, 8'h5A, 8'h00, 1, 0, 1, 1, 1, 1);
    tbl[35] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h5A, 8'h00, 1, 0, 1, 1, 1, 1);

    for (int i = 0; i < 36; i++) begin
      apply(tbl[i]);
      check_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Invalid init_resp code 8'h0C on an empty PD queue.
    v = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1);
    apply(v);
    check_vec(v, "drain_pd");
`ifdef AUTH_REQ_DROP_INVALID_EN
    v = mk(1, 1, 8'h0C, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1);
    v.err = 1'b1;
`else
    v = mk(1, 1, 8'h0C, 0, 0, 8'h00, 0, 8'h0C, 8'h00, 1, 0, 1, 1, 1, 1);
`endif
    apply(v);
    check_vec(v, "invalid_push");
`ifdef AUTH_REQ_DROP_INVALID_EN
    v = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1);
`else
    v = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h0C, 8'h00, 1, 0, 1, 1, 1, 1);
`endif
    apply(v);
    check_vec(v, "invalid_after");
    v = mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1);
    apply(v);
    check_vec(v, "invalid_drain");

    // Reset, then hold DEBUG at count 2 with push+pop pairs so the pointers wrap several times.
    step_model("wrap_rst", 0, 0, 8'h00, 0, 0, 8'h00, 1);
    step_model("wrap_fill0", 1, 0, 8'h00, 0, 1, 8'h10, 1);
    step_model("wrap_fill1", 1, 0, 8'h00, 0, 1, 8'h11, 0);
    for (int i = 0; i < 3 * Depth; i++) begin
      step_model($sformatf("wrap%0d_a", i), 1, 0, 8'h00, 0, 1, 8'(8'h12 + i), 1);
      step_model($sformatf("wrap%0d_b", i), 1, 0, 8'h00, 0, 0, 8'h00, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step_model($sformatf("wrap_drain%0d_a", i), 1, 0, 8'h00, 0, 0, 8'h00, 1);
      step_model($sformatf("wrap_drain%0d_b", i), 1, 0, 8'h00, 0, 0, 8'h00, 0);
    end

    // Random concurrent traffic on both queues with a reset in the middle.
    for (int i = 0; i < 250; i++) begin
      pd_d      = 8'($urandom);
      pd_d[5:4] = 2'($urandom_range(1, 2));
      db_d      = 8'($urandom);
      db_d[5:4] = 2'($urandom_range(1, 2));
      step_model($sformatf("rnd%0d", i), (i != 150), 1'($urandom_range(0, 1)), pd_d,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), db_d,
                 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
